// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, bank state encoding and bit-reversal helper.
package fft_pkg;
   localparam int N_POINTS = 8;
   localparam int LOG2N = 3;
   localparam int DATA_W = 21;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } cplx_t;
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
      return r;
   endfunction
endpackage

// File: rtl/fft_input_reorder_if.sv
// fft_input_reorder_if: natural-order sample stream in, bit-reversed operand pairs out.
interface fft_input_reorder_if;
   import fft_pkg::*;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_real;
   logic [DATA_W-1:0] in_imag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_real_a;
   logic [DATA_W-1:0] out_imag_a;
   logic [DATA_W-1:0] out_real_b;
   logic [DATA_W-1:0] out_imag_b;
   logic [LOG2N-2:0]  out_pair_idx;
   logic              out_last;
   modport master (
      output in_valid, in_real, in_imag, out_ready,
      input  in_ready, out_valid, out_real_a, out_imag_a, out_real_b, out_imag_b, out_pair_idx, out_last
   );
   modport slave (
      input  in_valid, in_real, in_imag, out_ready,
      output in_ready, out_valid, out_real_a, out_imag_a, out_real_b, out_imag_b, out_pair_idx, out_last
   );
endinterface

// File: rtl/fft_bank_mem.sv
// fft_bank_mem: one N_POINTS-deep complex bank, synchronous write, pair-wise asynchronous read.
module fft_bank_mem
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             we_i,
   input  logic [LOG2N-1:0] waddr_i,
   input  cplx_t            wdata_i,
   input  logic [LOG2N-2:0] pair_i,
   output cplx_t            a_o,
   output cplx_t            b_o
);
   cplx_t mem_q [N_POINTS];
   always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
   assign a_o = mem_q[{pair_i, 1'b0}];
   assign b_o = mem_q[{pair_i, 1'b1}];
endmodule

// File: rtl/fft_input_reorder.sv
// fft_input_reorder: ping-pong bit-reversal buffer feeding first-stage DIT butterfly pairs.
module fft_input_reorder
   import fft_pkg::*;
(
   input logic               clk,
   input logic               rst,
   fft_input_reorder_if.slave bus
);
   bank_state_t      bank_q [2], bank_d [2];
   logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
   logic [LOG2N-2:0] rd_cnt_q, rd_cnt_d, idx_q, idx_d;
   logic             valid_q, valid_d, last_q, last_d;
   cplx_t            a_q, a_d, b_q, b_d, wdata;
   cplx_t            rd_a [2], rd_b [2];
   logic             in_fire, load, wr_last, rd_last;
   assign bus.in_ready = bank_q[wr_ptr_q] == EMPTY || bank_q[wr_ptr_q] == FILLING;
   assign in_fire = bus.in_valid && bus.in_ready;
   assign load = (bank_q[rd_ptr_q] == FULL || bank_q[rd_ptr_q] == DRAINING) && (!valid_q || bus.out_ready);
   assign wr_last = wr_cnt_q == LOG2N'(N_POINTS - 1);
   assign rd_last = rd_cnt_q == (LOG2N-1)'(N_POINTS / 2 - 1);
   assign wdata = {bus.in_real, bus.in_imag};
   for (genvar g = 0; g < 2; g++) begin : g_bank
      fft_bank_mem u_mem (
         .clk     (clk),
         .we_i    (in_fire && wr_ptr_q == 1'(g)),
         .waddr_i (bitrev(wr_cnt_q)),
         .wdata_i (wdata),
         .pair_i  (rd_cnt_q),
         .a_o     (rd_a[g]),
         .b_o     (rd_b[g])
      );
   end
   // Write and read never target the same bank: their state sets are disjoint.
   always_comb begin
      bank_d = bank_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      valid_d = valid_q && !bus.out_ready;
      idx_d = idx_q;
      last_d = last_q;
      a_d = a_q;
      b_d = b_q;
      if (in_fire) begin
         bank_d[wr_ptr_q] = wr_last ? FULL : FILLING;
         wr_cnt_d = wr_cnt_q + LOG2N'(1);
         wr_ptr_d = wr_ptr_q ^ wr_last;
      end
      if (load) begin
         bank_d[rd_ptr_q] = rd_last ? EMPTY : DRAINING;
         rd_cnt_d = rd_cnt_q + (LOG2N-1)'(1);
         rd_ptr_d = rd_ptr_q ^ rd_last;
         valid_d = 1'b1;
         idx_d = rd_cnt_q;
         last_d = rd_last;
         a_d = rd_a[rd_ptr_q];
         b_d = rd_b[rd_ptr_q];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q <= '{EMPTY, EMPTY};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         valid_q <= 1'b0;
         idx_q <= '0;
         last_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         bank_q <= bank_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         valid_q <= valid_d;
         idx_q <= idx_d;
         last_q <= last_d;
         a_q <= a_d;
         b_q <= b_d;
      end
   end
   assign bus.out_valid = valid_q;
   assign bus.out_real_a = a_q.re;
   assign bus.out_imag_a = a_q.im;
   assign bus.out_real_b = b_q.re;
   assign bus.out_imag_b = b_q.im;
   assign bus.out_pair_idx = idx_q;
   assign bus.out_last = last_q;
endmodule

// File: tb/tb_fft_input_reorder.sv
// tb_fft_input_reorder: scoreboard bench; reference pairs come from a frame-level bit-reversal model.
module tb_fft_input_reorder;
   import fft_pkg::*;
   localparam int PAIRS = N_POINTS / 2;
   typedef logic [4*DATA_W+LOG2N-1:0] exp_t;
   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    compared = 0, mismatched = 0, ready_mode = 1, stall_cycles = 0;
   exp_t  expq [$];
   cplx_t frame [$];
   exp_t  held;
   logic  stalled = 1'b0;

   fft_input_reorder_if bus ();
   fft_input_reorder dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic int rev(int n);
      int r = 0;
      for (int i = 0; i < LOG2N; i++) r = r * 2 + ((n >> i) & 1);
      return r;
   endfunction

   function automatic exp_t observed();
      return {bus.out_real_a, bus.out_imag_a, bus.out_real_b, bus.out_imag_b, bus.out_pair_idx, bus.out_last};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
      logic acc;
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_real = re;
      bus.in_imag = im;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         sync();
         t++;
      end while (!acc && t < 100);
      stall_cycles += t - 1;
      if (!acc) begin
         compared++;
         mismatched++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((expq.size() != 0 || bus.out_valid) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: %0d pairs outstanding, required 0", expq.size());
      end
      sync();
   endtask

   // Called right after the final write of a frame with the output side idle and ready.
   task automatic drain_timing(input string name);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check(name, bus.out_valid, c >= 1 && c <= 4);
      end
      sync();
   endtask

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         sync();
         bus.out_ready = (ready_mode == 1) || (ready_mode == 2 && !bus.out_ready) ||
                         (ready_mode == 3 && $urandom_range(0, 1) == 1);
      end
   end

   // Reference model and monitor.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         frame.delete();
         expq.delete();
         stalled = 1'b0;
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            frame.push_back({bus.in_real, bus.in_imag});
            if (frame.size() == N_POINTS) begin
               for (int k = 0; k < PAIRS; k++)
                  expq.push_back({frame[rev(2 * k)], frame[rev(2 * k + 1)], (LOG2N-1)'(k), k == PAIRS - 1});
               frame.delete();
            end
         end
         if (stalled) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", observed(), held);
         end
         stalled = bus.out_valid && !bus.out_ready;
         held = observed();
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_pair: got %h, required no pair", observed());
            end else check("pair", observed(), expq.pop_front());
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_real = '0;
      bus.in_imag = '0;
      #2;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_outputs", observed(), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      sync();
      // Natural-order frame, exact latency and drain shape.
      for (int i = 0; i < N_POINTS; i++) send(DATA_W'(i), DATA_W'(100 + i));
      drain_timing("s1_timing");
      wait_drain();
      // Three back-to-back frames.
      stall_cycles = 0;
      for (int i = 0; i < 3 * N_POINTS; i++) send(DATA_W'(1000 + i), DATA_W'(2000 + i));
      check("s2_no_stall", stall_cycles, 0);
      drain_timing("s2_timing");
      wait_drain();
      // Both banks held by stalled output.
      ready_mode = 0;
      sync();
      sync();
      for (int i = 0; i < 2 * N_POINTS; i++) send(DATA_W'(300 + i), DATA_W'(400 + i));
      @(negedge clk);
      check("s3_full_ready", bus.in_ready, 0);
      sync();
      bus.in_valid = 1'b1;
      bus.in_real = DATA_W'(500);
      bus.in_imag = DATA_W'(600);
      repeat (4) begin
         @(negedge clk);
         check("s3_held_ready", bus.in_ready, 0);
      end
      sync();
      ready_mode = 1;
      for (int i = 0; i < N_POINTS; i++) send(DATA_W'(500 + i), DATA_W'(600 + i));
      wait_drain();
      // Alternating backpressure during a drain.
      ready_mode = 2;
      sync();
      for (int i = 0; i < N_POINTS; i++) send(DATA_W'(700 + i), DATA_W'(800 + i));
      wait_drain();
      ready_mode = 1;
      sync();
      sync();
      // Extreme negative values.
      for (int i = 0; i < N_POINTS; i++)
         send(i[0] ? 21'h100000 : 21'h1FFFFF, i[0] ? 21'h1FFFFF : 21'h100000);
      wait_drain();
      // Reset with a stalled full frame and a partial frame in flight.
      ready_mode = 0;
      sync();
      sync();
      for (int i = 0; i < N_POINTS; i++) send(DATA_W'(900 + i), DATA_W'(950 + i));
      sync();
      sync();
      check("s6_pre_rst_valid", bus.out_valid, 1);
      for (int i = 0; i < 5; i++) send(DATA_W'(990 + i), DATA_W'(995 + i));
      #1 rst = 1'b1;
      #1;
      check("s6_rst_valid", bus.out_valid, 0);
      check("s6_rst_ready", bus.in_ready, 1);
      check("s6_rst_outputs", observed(), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("s6_idle", bus.out_valid, 0);
      end
      sync();
      ready_mode = 1;
      sync();
      sync();
      for (int i = 0; i < N_POINTS; i++) send(DATA_W'(i), DATA_W'(100 + i));
      drain_timing("s6_timing");
      wait_drain();
      // Randomized data, input gaps and backpressure.
      ready_mode = 3;
      for (int i = 0; i < 6 * N_POINTS; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
         send(DATA_W'($urandom()), DATA_W'($urandom()));
      end
      ready_mode = 1;
      wait_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
